// File: rtl/yuv2rgb_converter.sv
// BT.601 YUV 4:4:4 to packed RGB888 converter working SRAM-to-SRAM.
// One pixel pair per 8-cycle FSM pass: three plane reads, one compute, three writes.
module yuv2rgb_converter #(
  parameter int W        = 320,
  parameter int H        = 240,
  parameter int DW       = 16,
  parameter int AW       = 18,
  parameter int SRC_BASE = 115200,
  parameter int DST_BASE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_raddr,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          busy,
  output logic          done
);

  localparam int NP = W * H / 2;

  typedef enum logic [3:0] {
    IDLE, RD_Y, RD_U, RD_V, CAP, CALC, WR0, WR1, WR2, DONE
  } state_t;

  state_t        state;
  logic [AW-1:0] k;
  logic [AW-1:0] wc;

  logic [DW-1:0] y_word, u_word, v_word;
  logic [7:0]    r0, g0, b0, r1, g1, b1;
  logic [23:0]   rgb0, rgb1;

  function automatic logic [7:0] clip8(input logic signed [19:0] x);
    if (x < 20'sd0)
      return 8'd0;
    else if (x > 20'sd255)
      return 8'hFF;
    else
      return x[7:0];
  endfunction

  // Returns {R, G, B}; 20-bit signed intermediates cover the worst case (B raw ~534*256).
  function automatic logic [23:0] convert(input logic [7:0] yy, input logic [7:0] uu,
                                          input logic [7:0] vv);
    logic signed [19:0] ys, us, vs, r, g, b;
    ys = $signed({12'd0, yy}) - 20'sd16;
    us = $signed({12'd0, uu}) - 20'sd128;
    vs = $signed({12'd0, vv}) - 20'sd128;
    r  = (20'sd298 * ys + 20'sd409 * vs + 20'sd128) >>> 8;
    g  = (20'sd298 * ys - 20'sd100 * us - 20'sd208 * vs + 20'sd128) >>> 8;
    b  = (20'sd298 * ys + 20'sd516 * us + 20'sd128) >>> 8;
    return {clip8(r), clip8(g), clip8(b)};
  endfunction

  always_comb begin
    rgb0 = convert(y_word[7:0],  u_word[7:0],  v_word[7:0]);
    rgb1 = convert(y_word[15:8], u_word[15:8], v_word[15:8]);
  end

  // Datapath capture: plane words arrive one cycle after their address, results registered in CALC
  always_ff @(posedge clk) begin
    case (state)
      RD_U: y_word <= mem_rdata;
      RD_V: u_word <= mem_rdata;
      CAP:  v_word <= mem_rdata;
      CALC: begin
        {r0, g0, b0} <= rgb0;
        {r1, g1, b1} <= rgb1;
      end
      default: ;
    endcase
  end

  // Control FSM; all memory-side outputs are registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      wc        <= '0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_raddr <= AW'(SRC_BASE);
      mem_waddr <= AW'(DST_BASE);
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RD_Y;
            busy      <= 1'b1;
            k         <= '0;
            wc        <= '0;
            mem_raddr <= AW'(SRC_BASE);
          end
        end
        RD_Y: begin
          state     <= RD_U;
          mem_raddr <= AW'(SRC_BASE + NP) + k;
        end
        RD_U: begin
          state     <= RD_V;
          mem_raddr <= AW'(SRC_BASE + 2 * NP) + k;
        end
        RD_V: state <= CAP;
        CAP:  state <= CALC;
        CALC: begin
          state     <= WR0;
          mem_we    <= 1'b1;
          mem_waddr <= AW'(DST_BASE) + wc;
          wc        <= wc + AW'(1);
          mem_wdata <= {rgb0[15:8], rgb0[23:16]};
        end
        WR0: begin
          state     <= WR1;
          mem_waddr <= AW'(DST_BASE) + wc;
          wc        <= wc + AW'(1);
          mem_wdata <= {r1, b0};
        end
        WR1: begin
          state     <= WR2;
          mem_waddr <= AW'(DST_BASE) + wc;
          wc        <= wc + AW'(1);
          mem_wdata <= {b1, g1};
        end
        WR2: begin
          mem_we <= 1'b0;
          if (k == AW'(NP - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= RD_Y;
            k         <= k + AW'(1);
            mem_raddr <= AW'(SRC_BASE) + k + AW'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
